// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM encoding, widths,
// and the RAM-port request bundle used by the mux.
package program_loader_pkg;

    localparam int unsigned RAM_ADDR_WIDTH = 4;
    localparam int unsigned BUS_WIDTH      = 8;
    localparam int unsigned LOAD_DEPTH     = 1 << RAM_ADDR_WIDTH;
    localparam int unsigned COUNT_WIDTH    = RAM_ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_WAIT_T0 = 3'd1,
        LD_RECV    = 3'd2,
        LD_WRITE   = 3'd3,
        LD_RELEASE = 3'd4
    } ld_state_e;

    typedef struct packed {
        logic [RAM_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [BUS_WIDTH-1:0]      wdata;
    } ram_req_t;

    // States in which the loader owns the RAM and holds the CPU
    function automatic logic ld_owns_ram(input ld_state_e st);
        return (st == LD_RECV) || (st == LD_WRITE) || (st == LD_RELEASE);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Loader-facing bundle: load control, byte stream, CPU RAM strobes,
// muxed RAM port and loader status.
interface program_loader_if;
    import program_loader_pkg::*;

    logic                      load_start;
    logic                      cycle_boundary;
    logic                      in_valid;
    logic [BUS_WIDTH-1:0]      in_data;
    logic                      in_last;
    logic                      in_ready;
    logic [RAM_ADDR_WIDTH-1:0] cpu_addr;
    logic                      cpu_we;
    logic [BUS_WIDTH-1:0]      cpu_wdata;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic                      ram_we;
    logic [BUS_WIDTH-1:0]      ram_wdata;
    logic                      cpu_hold;
    logic                      load_busy;
    logic                      load_done;
    logic [COUNT_WIDTH-1:0]    byte_count;

    modport slave (
        input  load_start, cycle_boundary, in_valid, in_data, in_last,
        input  cpu_addr, cpu_we, cpu_wdata,
        output in_ready, ram_addr, ram_we, ram_wdata,
        output cpu_hold, load_busy, load_done, byte_count
    );

    modport master (
        output load_start, cycle_boundary, in_valid, in_data, in_last,
        output cpu_addr, cpu_we, cpu_wdata,
        input  in_ready, ram_addr, ram_we, ram_wdata,
        input  cpu_hold, load_busy, load_done, byte_count
    );

endinterface

// File: rtl/program_loader_ram_port_mux.sv
// Combinational RAM port select: CPU strobes pass straight through unless
// the loader owns the RAM.
module ram_port_mux
    import program_loader_pkg::*;
(
    input  logic     i_sel_loader,
    input  ram_req_t i_cpu,
    input  ram_req_t i_ldr,
    output ram_req_t o_ram
);

    assign o_ram = i_sel_loader ? i_ldr : i_cpu;

endmodule

// File: rtl/program_loader.sv
// Loads a program image from a valid/ready byte stream into RAM while the
// CPU is held at T0, then releases the CPU to restart from address 0.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = BUS_WIDTH,
    parameter int unsigned DEPTH      = LOAD_DEPTH
) (
    input  logic             base_clk,
    input  logic             reset_ring,
    program_loader_if.slave  bus
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    ld_state_e              r_state;
    ld_state_e              w_state_next;

    logic                   r_in_ready;
    logic                   r_cpu_hold;
    logic                   r_load_busy;
    logic                   r_load_done;
    logic                   r_ram_we;
    logic                   r_last;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [CNT_W-1:0]       r_byte_count;

    logic                   w_start_load;
    logic                   w_accept;
    logic                   w_write;
    logic [CNT_W-1:0]       w_count_inc;

    ram_req_t               w_cpu_req;
    ram_req_t               w_ldr_req;
    ram_req_t               w_ram_req;

    assign w_count_inc = r_byte_count + CNT_W'(1);

    // State register
    always_ff @(posedge base_clk or posedge reset_ring) begin
        if (reset_ring) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        w_state_next = r_state;
        w_start_load = 1'b0;
        w_accept     = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            LD_IDLE: begin
                if (bus.load_start) begin
                    w_state_next = LD_WAIT_T0;
                end
            end
            LD_WAIT_T0: begin
                if (bus.cycle_boundary) begin
                    w_start_load = 1'b1;
                    w_state_next = LD_RECV;
                end
            end
            LD_RECV: begin
                if (bus.in_valid && r_in_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = LD_WRITE;
                end
            end
            LD_WRITE: begin
                w_write = 1'b1;
                // Stop on the marked last byte or once the RAM is full; never wrap
                if (r_last || (w_count_inc == CNT_W'(DEPTH))) begin
                    w_state_next = LD_RELEASE;
                end else begin
                    w_state_next = LD_RECV;
                end
            end
            LD_RELEASE: begin
                w_state_next = LD_IDLE;
            end
            default: begin
                w_state_next = LD_IDLE;
            end
        endcase
    end

    // Write address, byte count and latched stream byte
    always_ff @(posedge base_clk or posedge reset_ring) begin
        if (reset_ring) begin
            r_wr_addr    <= '0;
            r_byte_count <= '0;
            r_data       <= '0;
            r_last       <= 1'b0;
        end else begin
            if (w_start_load) begin
                r_wr_addr    <= '0;
                r_byte_count <= '0;
            end
            if (w_accept) begin
                r_data <= bus.in_data;
                r_last <= bus.in_last;
            end
            if (w_write) begin
                r_wr_addr    <= r_wr_addr + ADDR_WIDTH'(1);
                r_byte_count <= w_count_inc;
            end
        end
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge base_clk or posedge reset_ring) begin
        if (reset_ring) begin
            r_in_ready  <= 1'b0;
            r_ram_we    <= 1'b0;
            r_load_done <= 1'b0;
            r_load_busy <= 1'b0;
            r_cpu_hold  <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == LD_RECV);
            r_ram_we    <= (w_state_next == LD_WRITE);
            r_load_done <= (w_state_next == LD_RELEASE);
            r_load_busy <= ld_owns_ram(w_state_next);
            r_cpu_hold  <= ld_owns_ram(w_state_next);
        end
    end

    assign w_cpu_req.addr  = bus.cpu_addr;
    assign w_cpu_req.we    = bus.cpu_we;
    assign w_cpu_req.wdata = bus.cpu_wdata;

    assign w_ldr_req.addr  = r_wr_addr;
    assign w_ldr_req.we    = r_ram_we;
    assign w_ldr_req.wdata = r_data;

    ram_port_mux u_ram_port_mux (
        .i_sel_loader (r_load_busy),
        .i_cpu        (w_cpu_req),
        .i_ldr        (w_ldr_req),
        .o_ram        (w_ram_req)
    );

    assign bus.ram_addr   = w_ram_req.addr;
    assign bus.ram_we     = w_ram_req.we;
    assign bus.ram_wdata  = w_ram_req.wdata;
    assign bus.in_ready   = r_in_ready;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.load_busy  = r_load_busy;
    assign bus.load_done  = r_load_done;
    assign bus.byte_count = r_byte_count;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Sequences loading of a program image into the 16-byte RAM from an external byte stream (valid/ready), then hands the RAM back to the CPU.
- Sits between the controller's RAM-side strobes and the RAM. Owns the RAM address/write mux.
- Holds the CPU frozen and its ring counter reset while loading.
- After loading, releases the CPU to fetch from address 0.

Parameters:
- ADDR_WIDTH, 4, RAM address width (matches MAR).
- DATA_WIDTH, 8, RAM/bus word width.
- DEPTH, 16, maximum bytes per load; must equal 2**ADDR_WIDTH.

Ports:
- base_clk  input  1  system clock. Same clock that feeds the controller.
- reset_ring  input  1  asynchronous, active-high reset.
- load_start  input  1  one-cycle pulse that requests a load.
- cycle_boundary  input  1  high while the controller's ring counter is at T0.
- in_valid  input  1  byte-stream valid.
- in_data  input  DATA_WIDTH  byte-stream data.
- in_last  input  1  marks the final byte; qualified by in_valid.
- in_ready  output  1  loader accepts in_data this cycle.
- cpu_addr  input  ADDR_WIDTH  MAR contents from the CPU.
- cpu_we  input  1  controller store strobe.
- cpu_wdata  input  DATA_WIDTH  bus value for a CPU store.
- ram_addr  output  ADDR_WIDTH  muxed RAM address.
- ram_we  output  1  muxed RAM write enable.
- ram_wdata  output  DATA_WIDTH  muxed RAM write data.
- cpu_hold  output  1  freezes the CPU clock gate and forces the ring reset.
- load_busy  output  1  loader owns the RAM.
- load_done  output  1  one-cycle pulse when the load completes.
- byte_count  output  ADDR_WIDTH+1  number of bytes written by the last or current load.

Behaviour:
- Reset: state=IDLE, in_ready=0, ram_we=0, cpu_hold=0, load_busy=0, load_done=0, byte_count=0, internal wr_addr=0, data register=0.
- RAM mux:
  - When load_busy=0: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata (combinational pass-through).
  - When load_busy=1: all three RAM outputs come from the loader; CPU inputs are ignored.
- FSM states: IDLE, WAIT_T0, RECV, WRITE, RELEASE.
- IDLE:
  - load_start=1 -> WAIT_T0.
  - A load_start that arrives in any other state is ignored.
- WAIT_T0:
  - Waits for cycle_boundary=1 so no CPU instruction is interrupted mid-microstep.
  - On that cycle: cpu_hold=1 and load_busy=1 from the next edge; byte_count cleared; wr_addr cleared; -> RECV.
- RECV:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data and in_last -> WRITE.
- WRITE:
  - Exactly one cycle: ram_we=1, ram_addr=wr_addr, ram_wdata=latched byte.
  - Next edge: wr_addr+1, byte_count+1.
  - If the latched in_last=1, or byte_count reaches DEPTH after the increment -> RELEASE; else -> RECV.
- Throughput: at most 1 byte per 2 clocks; in_ready=0 in WRITE.
- RELEASE:
  - One cycle: load_done=1.
  - load_busy and cpu_hold drop on the next edge -> IDLE.
  - CPU restarts with the ring at T0; the PC is cleared by the same cpu_hold that forces the ring reset.
- Overflow: never wraps. After DEPTH bytes the FSM goes to RELEASE; in_ready stays 0 afterwards, so any further stream bytes remain pending and are not consumed.
- A byte with in_valid=0 is never accepted. in_data is sampled only on the handshake cycle.
- reset_ring asserted in any state: returns to IDLE immediately, with all outputs at their reset values. A partially loaded image is left in RAM; byte_count reads 0.
- byte_count holds its final value in IDLE until the next load begins.

Decomposition:
- Shared package (or include file): state encodings LD_IDLE, LD_WAIT_T0, LD_RECV, LD_WRITE, LD_RELEASE; RAM_ADDR_WIDTH=4; BUS_WIDTH=8.
- One natural sub-module, ram_port_mux: the purely combinational CPU/loader select for addr, we and wdata.
- The FSM, counters and data register stay in program_loader.

Test Plan:
- Idle pass-through: load_busy=0, cpu_addr=4'hA, cpu_we=1, cpu_wdata=8'h3C -> ram_addr=A, ram_we=1, ram_wdata=3C in the same cycle; in_ready=0.
- Three-byte load:
  - Stimulus: load_start, cycle_boundary at cycle 3, then bytes 8'h01, 8'h12, 8'h2F with in_last on the third.
  - Required: writes to addresses 0,1,2 with those values; cpu_hold high throughout; load_done pulses once; byte_count=3; cpu_hold low the cycle after.
- Boundary wait: load_start while cycle_boundary=0 for 5 cycles -> cpu_hold and load_busy stay 0 and in_ready stays 0 until cycle_boundary=1.
- Full image:
  - Stimulus: 16 bytes 8'h00..8'h0F with no in_last, and a 17th byte offered.
  - Required: addresses 0..15 written; RELEASE after byte 16; byte_count=16; the 17th byte is never accepted (in_ready=0).
- Back-pressure: in_valid toggled 1,0,0,1 -> exactly 2 bytes accepted; ram_we high exactly twice; each ram_we occurs one cycle after its handshake.
- Reset mid-load: reset_ring asserted during WRITE of byte 2 -> ram_we, cpu_hold and load_busy go to 0 without waiting for a clock edge; state=IDLE; byte_count=0; a new load_start then works normally.
